// File: rtl/regdst_hazard_ctrl_pkg.sv
// rtl/regdst_hazard_ctrl_pkg.sv - shared widths and forwarding encodings for the destination-register controller
package regdst_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    // Register $0 is hardwired; it never produces a hazard or a forward.
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

endpackage

// File: rtl/regdst_hazard_ctrl_fwd_sel.sv
// rtl/regdst_hazard_ctrl_fwd_sel.sv - MEM/WB priority compare producing one EX operand forwarding select
// Ports:
//   mem_valid, mem_we, mem_dst : instruction currently in MEM
//   wb_valid,  wb_we,  wb_dst  : instruction currently in WB
//   src                        : EX operand register index (rs or rt)
//   sel                        : FWD_MEM / FWD_WB / FWD_RF
module regdst_hazard_ctrl_fwd_sel #(
    parameter int REG_W = 5
) (
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             wb_valid,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_dst,
    input  logic [REG_W-1:0] src,
    output logic [1:0]       sel
);
    import regdst_hazard_ctrl_pkg::*;

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid & mem_we & (mem_dst != REG_W'(REG_ZERO)) & (mem_dst == src);
    assign wb_hit  = wb_valid  & wb_we  & (wb_dst  != REG_W'(REG_ZERO)) & (wb_dst  == src);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/regdst_hazard_ctrl.sv
// rtl/regdst_hazard_ctrl.sv - destination-mux select, EX/MEM/WB destination shadows, load-use stall and forwarding
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   id_valid .. id_rd              : decoded fields of the ID-stage instruction
//   flush                          : kill the ID instruction (taken branch)
//   regdst_sel                     : destination mux select, 1 = rd, 0 = rt
//   stall                          : hold PC and IF/ID, bubble into EX
//   fwd_a, fwd_b                   : EX operand source selects
//   ex_dst, mem_dst, wb_dst        : destination carried in each stage
//   wb_we                          : register-file write enable
//   stall_cnt                      : saturating count of stall cycles
module regdst_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rtype,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             flush,
    output logic             regdst_sel,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cnt
);
    import regdst_hazard_ctrl_pkg::*;

    logic             ex_valid;
    logic             ex_we;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             mem_valid;
    logic             mem_we;
    logic             wb_valid;
    logic             wb_we_reg;

    logic [REG_W-1:0] id_dst;
    logic             rs_match;
    logic             rt_match;
    logic             haz;
    logic             bubble;

    assign regdst_sel = id_rtype;
    assign id_dst     = id_rtype ? id_rd : id_rt;

    // Load-use: the load in EX has no data until MEM, so an ID consumer must wait one cycle.
    assign rs_match = (ex_dst == id_rs);
    assign rt_match = id_uses_rt & (ex_dst == id_rt);
    assign haz      = id_valid & ex_valid & ex_mem_read & ex_we
                    & (ex_dst != REG_W'(REG_ZERO)) & (rs_match | rt_match);

    // A flushed instruction is discarded anyway, so stalling for it would waste a cycle.
    assign stall  = haz & ~flush;
    assign bubble = stall | flush;

    assign wb_we = wb_valid & wb_we_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_dst      <= '0;
            ex_we       <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            mem_valid   <= 1'b0;
            mem_dst     <= '0;
            mem_we      <= 1'b0;
            wb_valid    <= 1'b0;
            wb_dst      <= '0;
            wb_we_reg   <= 1'b0;
        end else begin
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_dst      <= '0;
                ex_we       <= 1'b0;
                ex_mem_read <= 1'b0;
                ex_rs       <= '0;
                ex_rt       <= '0;
            end else begin
                ex_valid    <= id_valid;
                ex_dst      <= id_dst;
                ex_we       <= id_reg_write;
                ex_mem_read <= id_mem_read;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
            end
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            mem_we    <= ex_we;
            wb_valid  <= mem_valid;
            wb_dst    <= mem_dst;
            wb_we_reg <= mem_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    regdst_hazard_ctrl_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_dst   (mem_dst),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we_reg),
        .wb_dst    (wb_dst),
        .src       (ex_rs),
        .sel       (fwd_a)
    );

    regdst_hazard_ctrl_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_dst   (mem_dst),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we_reg),
        .wb_dst    (wb_dst),
        .src       (ex_rt),
        .sel       (fwd_b)
    );

endmodule

// File: tb/tb_regdst_hazard_ctrl.sv
// tb/tb_regdst_hazard_ctrl.sv - self-checking bench for regdst_hazard_ctrl
module tb_regdst_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic i_valid, i_rtype, i_rw, i_mr, i_ur, i_flush;
    logic [4:0] i_rs, i_rt, i_rd;

    logic        regdst_sel, stall, wb_we;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic [15:0] stall_cnt;

    logic        regdst_sel2, stall2, wb_we2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [4:0]  ex_dst2, mem_dst2, wb_dst2;
    logic [1:0]  stall_cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         valid;
        logic [4:0] dst;
        bit         we;
        bit         mr;
        logic [4:0] rs;
        logic [4:0] rt;
    } stg_t;

    stg_t m_ex, m_mem, m_wb;
    int   cnt16, cnt2;

    always #5 clk = ~clk;

    regdst_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(i_valid), .id_rtype(i_rtype), .id_reg_write(i_rw),
        .id_mem_read(i_mr), .id_uses_rt(i_ur), .id_rs(i_rs), .id_rt(i_rt), .id_rd(i_rd),
        .flush(i_flush), .regdst_sel(regdst_sel), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst), .wb_we(wb_we), .stall_cnt(stall_cnt)
    );

    regdst_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(i_valid), .id_rtype(i_rtype), .id_reg_write(i_rw),
        .id_mem_read(i_mr), .id_uses_rt(i_ur), .id_rs(i_rs), .id_rt(i_rt), .id_rd(i_rd),
        .flush(i_flush), .regdst_sel(regdst_sel2), .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .ex_dst(ex_dst2), .mem_dst(mem_dst2), .wb_dst(wb_dst2), .wb_we(wb_we2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stg_t empty_stage();
        stg_t s;
        s.valid = 0; s.dst = '0; s.we = 0; s.mr = 0; s.rs = '0; s.rt = '0;
        return s;
    endfunction

    task automatic model_reset();
        m_ex  = empty_stage();
        m_mem = empty_stage();
        m_wb  = empty_stage();
        cnt16 = 0;
        cnt2  = 0;
    endtask

    // A stall is owed when the EX instruction is a real load whose nonzero destination is among the registers ID reads.
    function automatic bit model_haz();
        logic [4:0] srcs[$];
        if (!i_valid || !(m_ex.valid && m_ex.mr && m_ex.we) || m_ex.dst == 5'd0) return 0;
        srcs.push_back(i_rs);
        if (i_ur) srcs.push_back(i_rt);
        foreach (srcs[k]) if (srcs[k] == m_ex.dst) return 1;
        return 0;
    endfunction

    // Youngest older writer of the register supplies the operand.
    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        stg_t       older[2];
        logic [1:0] code[2];
        older[0] = m_mem; code[0] = 2'b10;
        older[1] = m_wb;  code[1] = 2'b01;
        for (int k = 0; k < 2; k++)
            if (older[k].valid && older[k].we && older[k].dst != 5'd0 && older[k].dst == src) return code[k];
        return 2'b00;
    endfunction

    task automatic check_all();
        bit exp_stall;
        exp_stall = model_haz() && !i_flush;
        chk("regdst_sel", regdst_sel, i_rtype);
        chk("stall", stall, exp_stall);
        chk("stall_w2", stall2, exp_stall);
        chk("fwd_a", fwd_a, model_fwd(m_ex.rs));
        chk("fwd_b", fwd_b, model_fwd(m_ex.rt));
        chk("ex_dst", ex_dst, m_ex.dst);
        chk("mem_dst", mem_dst, m_mem.dst);
        chk("wb_dst", wb_dst, m_wb.dst);
        chk("wb_we", wb_we, m_wb.valid && m_wb.we);
        chk("stall_cnt", stall_cnt, cnt16);
        chk("stall_cnt_w2", stall_cnt2, cnt2);
    endtask

    task automatic model_advance();
        bit st;
        st = model_haz() && !i_flush;
        if (st) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt2 < 3) cnt2++;
        end
        m_wb  = m_mem;
        m_mem = m_ex;
        if (st || i_flush) begin
            m_ex = empty_stage();
        end else begin
            m_ex.valid = i_valid;
            m_ex.dst   = i_rtype ? i_rd : i_rt;
            m_ex.we    = i_rw;
            m_ex.mr    = i_mr;
            m_ex.rs    = i_rs;
            m_ex.rt    = i_rt;
        end
    endtask

    task automatic set_in(input bit v, input bit rty, input bit rw, input bit mr, input bit ur,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input bit fl);
        @(negedge clk);
        i_valid = v; i_rtype = rty; i_rw = rw; i_mr = mr; i_ur = ur;
        i_rs = rs; i_rt = rt; i_rd = rd; i_flush = fl;
        #1;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) begin
            set_idle();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 0; i_rtype = 0; i_rw = 0; i_mr = 0; i_ur = 0;
        i_rs = '0; i_rt = '0; i_rd = '0; i_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_stall", stall, 1'b0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // rd chosen for R-type, then rt for I-type
        set_in(1, 1, 1, 0, 1, 5'd0, 5'b01010, 5'b10101, 0);
        chk("regdst_r", regdst_sel, 1'b1);
        tick();
        set_idle(); tick();
        set_idle(); tick();
        chk("wb_dst_r", wb_dst, 5'b10101);
        chk("wb_we_r", wb_we, 1'b1);
        set_in(1, 0, 1, 0, 0, 5'd0, 5'b01010, 5'b10101, 0);
        chk("regdst_i", regdst_sel, 1'b0);
        tick();
        set_idle(); tick();
        set_idle(); tick();
        chk("wb_dst_i", wb_dst, 5'b01010);
        chk("wb_we_i", wb_we, 1'b1);
        drain();

        // load-use on $8: one stall cycle, then WB forward
        set_in(1, 0, 1, 1, 0, 5'd0, 5'd8, 5'd0, 0);
        tick();
        set_in(1, 1, 1, 0, 1, 5'd8, 5'd9, 5'd10, 0);
        chk("lu_stall", stall, 1'b1);
        tick();
        chk("lu_bubble", ex_dst, 5'd0);
        chk("lu_mem_dst", mem_dst, 5'd8);
        chk("lu_cnt", stall_cnt, 16'd1);
        set_in(1, 1, 1, 0, 1, 5'd8, 5'd9, 5'd10, 0);
        chk("lu_stall_end", stall, 1'b0);
        tick();
        chk("lu_fwd_wb", fwd_a, 2'b01);
        drain();

        // forwarding priority on $3
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd3, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd3, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd3, 5'd3, 5'd6, 0); tick();
        chk("prio_mem_a", fwd_a, 2'b10);
        chk("prio_mem_b", fwd_b, 2'b10);
        drain();
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd3, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd4, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd3, 5'd1, 5'd6, 0); tick();
        chk("prio_wb_a", fwd_a, 2'b01);
        drain();
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd0, 5'd0, 5'd6, 0); tick();
        chk("prio_zero_a", fwd_a, 2'b00);
        drain();

        // flush beats a simultaneous load-use hazard
        set_in(1, 0, 1, 1, 0, 5'd0, 5'd8, 5'd0, 0);
        tick();
        set_in(1, 1, 1, 0, 1, 5'd8, 5'd9, 5'd10, 1);
        chk("flush_stall", stall, 1'b0);
        tick();
        chk("flush_bubble", ex_dst, 5'd0);
        chk("flush_cnt", stall_cnt, 16'd1);
        drain();

        // five stalls saturate a 2-bit counter
        for (int n = 0; n < 5; n++) begin
            set_in(1, 0, 1, 1, 0, 5'd0, 5'd7, 5'd0, 0); tick();
            set_in(1, 1, 1, 0, 1, 5'd7, 5'd2, 5'd11, 0); tick();
            set_idle(); tick();
        end
        chk("sat_cnt2", stall_cnt2, 2'd3);
        chk("sat_cnt16", stall_cnt, 16'd6);

        // random traffic over a small register set to provoke hazards and forwards
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 7) == 0);
            tick();
        end

        // reset with the pipeline loaded
        set_in(1, 1, 1, 0, 1, 5'd1, 5'd2, 5'd5, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd1, 5'd2, 5'd5, 0); tick();
        set_in(1, 1, 1, 0, 1, 5'd5, 5'd5, 5'd5, 0); tick();
        chk("pre_rst_wb_we", wb_we, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wb_we", wb_we, 1'b0);
        chk("mid_rst_cnt", stall_cnt, 16'd0);
        chk("mid_rst_ex", ex_dst, 5'd0);
        chk("mid_rst_mem", mem_dst, 5'd0);
        chk("mid_rst_wb", wb_dst, 5'd0);
        chk("mid_rst_fwd_a", fwd_a, 2'b00);
        model_reset();
        set_idle();
        rst = 1'b0;
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regdst_hazard_ctrl.md
Name: regdst_hazard_ctrl

Overview:
Controller for the pipeline's destination-register datapath. It drives the select of the 5-bit destination mux (rt vs rd) in ID and carries the chosen destination through EX/MEM/WB shadow registers. It detects load-use hazards and requests a one-cycle stall with bubble insertion. It also produces EX-stage forwarding selects and a saturating stall counter for debug.

Parameters:
REG_W, 5, register-index width (matches destination mux width)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rtype  in  1  ID instruction is R-type (destination = rd)
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
id_uses_rt  in  1  ID instruction reads rt as a source
id_rs  in  REG_W  ID source rs
id_rt  in  REG_W  ID source rt / I-type destination
id_rd  in  REG_W  ID R-type destination
flush  in  1  kill the ID instruction (taken branch)
regdst_sel  out  1  destination-mux select: 1 = rd (B input), 0 = rt (A input)
stall  out  1  hold PC and IF/ID, insert bubble in EX
fwd_a  out  2  EX operand A source: 00 regfile, 10 MEM, 01 WB
fwd_b  out  2  EX operand B source, same encoding
ex_dst, mem_dst, wb_dst  out  REG_W  destination carried in each stage
wb_we  out  1  register-file write enable (valid and reg_write in WB)
stall_cnt  out  CNT_W  number of stall cycles, saturating

Behaviour:
- Clock, reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valid, we and mem_read bits 0. All dst, rs and rt regs 0. stall_cnt 0.
- Reset outputs: wb_we 0, fwd_a and fwd_b 00, stall 0, regdst_sel = id_rtype.
- regdst_sel: combinational, equals id_rtype.
- id_dst: id_rtype ? id_rd : id_rt. This mirrors the mux exactly.
- Pipeline: every rising edge, EX <- ID, MEM <- EX, WB <- MEM. There is no enable, because downstream never stalls.
- EX stage contents: {valid, dst, we, mem_read, rs, rt}.
- MEM and WB stage contents: {valid, dst, we}.
- Bubble: when stall or flush is high, EX captures valid = 0 and we = 0. The other EX fields are don't-care and are captured as 0.
- Hazard: haz = id_valid & ex_valid & ex_mem_read & ex_we & (ex_dst != 0) & (ex_dst == id_rs | (id_uses_rt & ex_dst == id_rt)).
- Stall output: stall = haz & !flush. It is combinational, in the same cycle.
- Stall length: one load-use stall lasts exactly 1 cycle, because the load has moved to MEM on the next cycle.
- Forwarding, MEM source: fwd_a = 10 if mem_valid & mem_we & mem_dst != 0 & mem_dst == ex_rs.
- Forwarding, WB source: otherwise fwd_a = 01 if the same test passes with WB fields.
- Forwarding, default: otherwise fwd_a = 00.
- Forwarding priority: MEM wins over WB.
- fwd_b: same rules using ex_rt.
- Register $0: never matches in the hazard or forwarding logic.
- wb_we: wb_valid & wb_we_reg, registered.
- stall_cnt: increments on each edge where stall = 1. It holds at all-ones.
- Simultaneous flush and haz: flush wins. stall = 0, a bubble is inserted, and the counter does not increment.
- Reset mid-operation: all in-flight entries are discarded immediately. Outputs take their reset values asynchronously.

Decomposition:
- Shared package holds:
  - REG_W
  - forward encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - REG_ZERO = 0
- One natural sub-module: fwd_sel. It is a combinational MEM/WB priority compare and is instantiated twice, for A and B.
- The stage registers stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with stages loaded -> all stage valids 0, wb_we 0, stall_cnt 0 immediately.
- RegDst: id_rtype = 1, rt = 5'b01010, rd = 5'b10101 -> regdst_sel = 1, and 3 cycles later wb_dst = 5'b10101 with wb_we = 1. Then id_rtype = 0 -> regdst_sel = 0, and wb_dst = 5'b01010 three cycles later.
- Load-use: lw writing $8, next cycle ID add reading rs = 8 -> stall = 1 for exactly one cycle, EX holds a bubble, stall_cnt = 1, then fwd_a = 01 when the add is in EX.
- Forward priority: MEM and WB both write $3, EX rs = 3 -> fwd_a = 10. With the MEM write removed -> fwd_a = 01. With dst = $0 -> fwd_a = 00.
- Flush vs hazard: load-use condition present while flush = 1 -> stall = 0, EX valid = 0, stall_cnt unchanged.
- Counter saturation: with CNT_W = 2, force 5 hazards -> stall_cnt stops at 3.
